// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad operand entry block.
//   key_e           : decoded key identity carried on key_code
//   entry_state_e   : operand entry phase
//   debounce_state_e: press/release tracking inside the scanner
//   code_to_key     : maps a matrix position (r*4+c) to a key identity
package keypad_pkg;

  typedef enum logic [4:0] {
    KEY_0    = 5'd0,
    KEY_1    = 5'd1,
    KEY_2    = 5'd2,
    KEY_3    = 5'd3,
    KEY_4    = 5'd4,
    KEY_5    = 5'd5,
    KEY_6    = 5'd6,
    KEY_7    = 5'd7,
    KEY_8    = 5'd8,
    KEY_9    = 5'd9,
    KEY_A    = 5'd10,
    KEY_B    = 5'd11,
    KEY_C    = 5'd12,
    KEY_D    = 5'd13,
    KEY_STAR = 5'd14,
    KEY_HASH = 5'd15,
    KEY_NONE = 5'd16
  } key_e;

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_DONE   = 2'd2
  } entry_state_e;

  typedef enum logic {
    DB_IDLE    = 1'b0,
    DB_PRESSED = 1'b1
  } debounce_state_e;

  localparam int unsigned DIGIT_MUL = 32'd10;

  // Physical layout: row0 1 2 3 A / row1 4 5 6 B / row2 7 8 9 C / row3 * 0 # D.
  // Positions beyond the 4x4 legend have no meaning and map to KEY_NONE.
  function automatic key_e code_to_key(input int unsigned code);
    key_e k;
    case (code)
      32'd0:   k = KEY_1;
      32'd1:   k = KEY_2;
      32'd2:   k = KEY_3;
      32'd3:   k = KEY_A;
      32'd4:   k = KEY_4;
      32'd5:   k = KEY_5;
      32'd6:   k = KEY_6;
      32'd7:   k = KEY_B;
      32'd8:   k = KEY_7;
      32'd9:   k = KEY_8;
      32'd10:  k = KEY_9;
      32'd11:  k = KEY_C;
      32'd12:  k = KEY_STAR;
      32'd13:  k = KEY_0;
      32'd14:  k = KEY_HASH;
      32'd15:  k = KEY_D;
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Keypad matrix scanner with row synchroniser, multi-key rejection and
// frame-based debounce.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   row_i         : active-low rows, asynchronous to clk_i
//   col_o         : active-low one-hot column drive
//   key_valid_o   : one-cycle pulse per accepted press
//   key_code_o    : key identity of the last accepted press
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_ROWS-1:0] row_i,
  output logic [N_COLS-1:0] col_o,
  output logic              key_valid_o,
  output key_e              key_code_o
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CODE_W = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end

  logic [N_ROWS-1:0] row_meta_q, row_sync_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [N_COLS-1:0] col_q, col_d;
  logic [1:0]        frame_hits_q, frame_hits_d;
  logic [CODE_W-1:0] frame_code_q, frame_code_d;
  debounce_state_e   db_state_q, db_state_d;
  logic [CODE_W-1:0] cand_code_q, cand_code_d;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic              key_valid_q, key_valid_d;
  key_e              key_code_q, key_code_d;

  logic              slot_end_s, frame_end_s;
  logic [1:0]        col_hits_s, tot_hits_s;
  logic [2:0]        hit_sum_s;
  logic [ROW_W-1:0]  col_row_s;
  logic [CODE_W-1:0] col_code_s, frame_code_s;
  logic [CNT_W-1:0]  cnt_next_s;
  key_e              frame_key_s;

  assign slot_end_s  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end_s = slot_end_s && (col_idx_q == COL_W'(N_COLS - 1));

  // Slot timer and column rotation; col_q always mirrors col_idx_q.
  always_comb begin
    div_d     = div_q + DIV_W'(1);
    col_idx_d = col_idx_q;
    if (slot_end_s) begin
      div_d = '0;
      if (col_idx_q == COL_W'(N_COLS - 1)) begin
        col_idx_d = '0;
      end else begin
        col_idx_d = col_idx_q + COL_W'(1);
      end
    end else begin
      col_idx_d = col_idx_q;
    end
    col_d = ~(N_COLS'(1) << col_idx_d);
  end

  // Count low rows in the current column (saturating at two) and note which one.
  always_comb begin
    col_hits_s = 2'd0;
    col_row_s  = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (!row_sync_q[r]) begin
        col_hits_s = (col_hits_s == 2'd2) ? 2'd2 : col_hits_s + 2'd1;
        col_row_s  = ROW_W'(r);
      end else begin
        col_hits_s = col_hits_s;
      end
    end
  end

  assign col_code_s   = CODE_W'(int'(col_row_s) * N_COLS + int'(col_idx_q));
  assign hit_sum_s    = {1'b0, frame_hits_q} + {1'b0, col_hits_s};
  assign tot_hits_s   = (hit_sum_s > 3'd2) ? 2'd2 : hit_sum_s[1:0];
  assign frame_code_s = (col_hits_s == 2'd1) ? col_code_s : frame_code_q;
  assign frame_key_s  = code_to_key(32'(frame_code_s));

  // Frame accumulator: hits so far this frame and the position of a single hit.
  always_comb begin
    frame_hits_d = frame_hits_q;
    frame_code_d = frame_code_q;
    if (frame_end_s) begin
      frame_hits_d = 2'd0;
      frame_code_d = '0;
    end else if (slot_end_s) begin
      frame_hits_d = tot_hits_s;
      frame_code_d = frame_code_s;
    end else begin
      frame_hits_d = frame_hits_q;
    end
  end

  // Debounce: evaluated once per frame; tot_hits 0 = none, 1 = single key, 2 = invalid.
  always_comb begin
    db_state_d  = db_state_q;
    cand_code_d = cand_code_q;
    db_cnt_d    = db_cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    cnt_next_s  = db_cnt_q + CNT_W'(1);
    if (frame_end_s) begin
      case (db_state_q)
        DB_IDLE: begin
          if (tot_hits_s == 2'd1) begin
            if ((db_cnt_q != '0) && (frame_code_s == cand_code_q)) begin
              cnt_next_s = db_cnt_q + CNT_W'(1);
            end else begin
              cnt_next_s = CNT_W'(1);
            end
            cand_code_d = frame_code_s;
            if (cnt_next_s == CNT_W'(DEBOUNCE_SCANS)) begin
              db_cnt_d   = '0;
              db_state_d = DB_PRESSED;
              // Positions with no legend are consumed silently.
              if (frame_key_s != KEY_NONE) begin
                key_valid_d = 1'b1;
                key_code_d  = frame_key_s;
              end else begin
                key_valid_d = 1'b0;
              end
            end else begin
              db_cnt_d = cnt_next_s;
            end
          end else begin
            db_cnt_d = '0;
          end
        end
        DB_PRESSED: begin
          if (tot_hits_s == 2'd0) begin
            if (cnt_next_s == CNT_W'(DEBOUNCE_SCANS)) begin
              db_cnt_d   = '0;
              db_state_d = DB_IDLE;
            end else begin
              db_cnt_d = cnt_next_s;
            end
          end else begin
            db_cnt_d = '0;
          end
        end
        default: begin
          db_state_d = DB_IDLE;
          db_cnt_d   = '0;
        end
      endcase
    end else begin
      db_cnt_d = db_cnt_q;
    end
  end

  // Synchroniser, scan and frame registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_meta_q   <= '1;
      row_sync_q   <= '1;
      div_q        <= '0;
      col_idx_q    <= '0;
      col_q        <= ~N_COLS'(1);
      frame_hits_q <= 2'd0;
      frame_code_q <= '0;
    end else begin
      row_meta_q   <= row_i;
      row_sync_q   <= row_meta_q;
      div_q        <= div_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      frame_hits_q <= frame_hits_d;
      frame_code_q <= frame_code_d;
    end
  end

  // Debounce state and key outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_state_q  <= DB_IDLE;
      cand_code_q <= '0;
      db_cnt_q    <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_NONE;
    end else begin
      db_state_q  <= db_state_d;
      cand_code_q <= cand_code_d;
      db_cnt_q    <= db_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col_o       = col_q;
  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad front end producing two signed decimal operands.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   row_i / col_o  : keypad matrix rows (active-low) and column drive
//   key_valid_o    : one-cycle pulse per debounced press
//   key_code_o     : keypad_pkg::key_e of the last press
//   first_num_o    : signed first operand, live
//   second_num_o   : signed second operand, live
//   entry_phase_o  : keypad_pkg::entry_state_e
//   ops_valid_o    : operand pair complete, held until ops_ready_i
//   ops_ready_i    : downstream accepts the pair
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 10,
  parameter int MAX_DIGITS     = 3,
  parameter int OP_WIDTH       = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [N_ROWS-1:0]          row_i,
  output logic [N_COLS-1:0]          col_o,
  output logic                       key_valid_o,
  output logic [4:0]                 key_code_o,
  output logic signed [OP_WIDTH-1:0] first_num_o,
  output logic signed [OP_WIDTH-1:0] second_num_o,
  output logic [1:0]                 entry_phase_o,
  output logic                       ops_valid_o,
  input  logic                       ops_ready_i
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam longint unsigned MAX_MAG = (64'd10 ** MAX_DIGITS) - 64'd1;

  if (((64'd1 << (OP_WIDTH - 1)) - 64'd1) < MAX_MAG) begin : g_bad_width
    $error("OP_WIDTH too small for MAX_DIGITS");
  end

  logic key_valid_s;
  key_e key_code_s;

  keypad_scan_debounce #(
    .N_ROWS        (N_ROWS),
    .N_COLS        (N_COLS),
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .row_i      (row_i),
    .col_o      (col_o),
    .key_valid_o(key_valid_s),
    .key_code_o (key_code_s)
  );

  // Index 0 is the first operand, index 1 the second.
  entry_state_e         state_q, state_d;
  logic [OP_WIDTH-1:0]  mag_q [2];
  logic [OP_WIDTH-1:0]  mag_d [2];
  logic                 neg_q [2];
  logic                 neg_d [2];
  logic [DCNT_W-1:0]    dcnt_q [2];
  logic [DCNT_W-1:0]    dcnt_d [2];
  logic                 ops_valid_q, ops_valid_d;
  logic signed [OP_WIDTH-1:0] first_num_q, first_num_d;
  logic signed [OP_WIDTH-1:0] second_num_q, second_num_d;
  logic                 cur_s;
  logic                 clear_all_s;

  assign cur_s       = (state_q == S_SECOND);
  assign clear_all_s = ((state_q == S_DONE) && ops_valid_q && ops_ready_i) ||
                       (key_valid_s && (key_code_s == KEY_STAR));

  // Entry FSM: next state, operand edits and handshake.
  always_comb begin
    state_d     = state_q;
    ops_valid_d = ops_valid_q;
    for (int i = 0; i < 2; i++) begin
      mag_d[i]  = mag_q[i];
      neg_d[i]  = neg_q[i];
      dcnt_d[i] = dcnt_q[i];
    end
    if (clear_all_s) begin
      state_d     = S_FIRST;
      ops_valid_d = 1'b0;
      for (int i = 0; i < 2; i++) begin
        mag_d[i]  = '0;
        neg_d[i]  = 1'b0;
        dcnt_d[i] = '0;
      end
    end else if (key_valid_s) begin
      case (state_q)
        S_FIRST, S_SECOND: begin
          if (key_code_s <= KEY_9) begin
            if (dcnt_q[cur_s] < DCNT_W'(MAX_DIGITS)) begin
              mag_d[cur_s]  = OP_WIDTH'(32'(mag_q[cur_s]) * DIGIT_MUL + 32'(key_code_s));
              dcnt_d[cur_s] = dcnt_q[cur_s] + DCNT_W'(1);
            end else begin
              mag_d[cur_s] = mag_q[cur_s];
            end
          end else begin
            case (key_code_s)
              KEY_B: neg_d[cur_s] = ~neg_q[cur_s];
              KEY_C: begin
                mag_d[cur_s]  = '0;
                neg_d[cur_s]  = 1'b0;
                dcnt_d[cur_s] = '0;
              end
              KEY_A: begin
                if (state_q == S_FIRST) begin
                  state_d = S_SECOND;
                end else begin
                  state_d = state_q;
                end
              end
              KEY_HASH, KEY_D: begin
                if (state_q == S_SECOND) begin
                  state_d     = S_DONE;
                  ops_valid_d = 1'b1;
                end else begin
                  state_d = state_q;
                end
              end
              default: state_d = state_q;
            endcase
          end
        end
        S_DONE:  state_d = S_DONE;
        default: begin
          state_d     = S_FIRST;
          ops_valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    // Sign flag survives a zero magnitude: -0 stays 0 until a digit arrives.
    first_num_d  = neg_d[0] ? (~mag_d[0] + OP_WIDTH'(1)) : mag_d[0];
    second_num_d = neg_d[1] ? (~mag_d[1] + OP_WIDTH'(1)) : mag_d[1];
  end

  // Entry state, operand and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_FIRST;
      ops_valid_q  <= 1'b0;
      first_num_q  <= '0;
      second_num_q <= '0;
      for (int i = 0; i < 2; i++) begin
        mag_q[i]  <= '0;
        neg_q[i]  <= 1'b0;
        dcnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ops_valid_q  <= ops_valid_d;
      first_num_q  <= first_num_d;
      second_num_q <= second_num_d;
      for (int i = 0; i < 2; i++) begin
        mag_q[i]  <= mag_d[i];
        neg_q[i]  <= neg_d[i];
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign key_valid_o   = key_valid_s;
  assign key_code_o    = key_code_s;
  assign first_num_o   = first_num_q;
  assign second_num_o  = second_num_q;
  assign entry_phase_o = state_q;
  assign ops_valid_o   = ops_valid_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry with a 4x4 keypad model that pulls
// a row low while its column is driven and the key is held.
module tb_keypad_operand_entry;
  import keypad_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [11:0] first_num;
  logic [11:0] second_num;
  logic [1:0]  entry_phase;
  logic        ops_valid;
  logic        ops_ready;

  logic [15:0] keys;      // held keys, bit index = r*4+c
  int          checks;
  int          errors;
  int          kv_count;
  int          kv_before;

  keypad_operand_entry #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(2),
    .MAX_DIGITS(3), .OP_WIDTH(12)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .row_i        (row),
    .col_o        (col),
    .key_valid_o  (key_valid),
    .key_code_o   (key_code),
    .first_num_o  (first_num),
    .second_num_o (second_num),
    .entry_phase_o(entry_phase),
    .ops_valid_o  (ops_valid),
    .ops_ready_i  (ops_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid === 1'b1) kv_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold one key until accepted (bounded), check its code, release and settle.
  task automatic press(input int code, input logic [4:0] exp_key, input string tag);
    logic seen;
    seen = 1'b0;
    keys[code] = 1'b1;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (key_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_code"}, 32'(key_code), 32'(exp_key));
    keys = 16'h0000;
    repeat (80) @(negedge clk);
  endtask

  logic [3:0] exp_col;

  initial begin
    checks = 0; errors = 0; kv_count = 0;
    keys = 16'h0000; ops_ready = 1'b0; rst_ni = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_col", 32'(col), 32'h0000000E);
    chk("rst_kv", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'(KEY_NONE));
    chk("rst_first", 32'(first_num), 32'd0);
    chk("rst_second", 32'(second_num), 32'd0);
    chk("rst_phase", 32'(entry_phase), 32'(S_FIRST));
    chk("rst_ovalid", 32'(ops_valid), 32'd0);

    // Idle column rotation
    rst_ni = 1'b1;
    kv_before = kv_count;
    for (int i = 1; i <= 8; i++) begin
      repeat (4) @(negedge clk);
      exp_col = ~(4'b0001 << (i % 4));
      chk("idle_col", 32'(col), 32'(exp_col));
    end
    repeat (32) @(negedge clk);
    chk("idle_nokv", 32'(kv_count), 32'(kv_before));
    chk("idle_first", 32'(first_num), 32'd0);

    // 12 A 34 #
    press(0, KEY_1, "k1");
    press(1, KEY_2, "k2");
    press(3, KEY_A, "kA");
    press(2, KEY_3, "k3");
    press(4, KEY_4, "k4");
    press(14, KEY_HASH, "kHash");
    chk("p1_first", 32'(first_num), 32'd12);
    chk("p1_second", 32'(second_num), 32'd34);
    chk("p1_valid", 32'(ops_valid), 32'd1);
    chk("p1_phase", 32'(entry_phase), 32'(S_DONE));
    repeat (20) @(negedge clk);
    chk("hold_first", 32'(first_num), 32'd12);
    chk("hold_second", 32'(second_num), 32'd34);
    chk("hold_valid", 32'(ops_valid), 32'd1);
    ops_ready = 1'b1;
    @(negedge clk);
    ops_ready = 1'b0;
    chk("xfer_valid", 32'(ops_valid), 32'd0);
    chk("xfer_first", 32'(first_num), 32'd0);
    chk("xfer_second", 32'(second_num), 32'd0);
    chk("xfer_phase", 32'(entry_phase), 32'(S_FIRST));

    // 5 B A 7 B 9 D -> -5, -79
    press(5, KEY_5, "k5");
    press(7, KEY_B, "kB");
    press(3, KEY_A, "kA2");
    press(8, KEY_7, "k7");
    press(7, KEY_B, "kB2");
    press(10, KEY_9, "k9");
    press(15, KEY_D, "kD");
    chk("neg_first", 32'(first_num), 32'h00000FFB);
    chk("neg_second", 32'(second_num), 32'h00000FB1);
    chk("neg_valid", 32'(ops_valid), 32'd1);
    press(0, KEY_1, "k1_done");
    chk("done_frozen", 32'(first_num), 32'h00000FFB);
    press(12, KEY_STAR, "kStar");
    chk("star_first", 32'(first_num), 32'd0);
    chk("star_second", 32'(second_num), 32'd0);
    chk("star_valid", 32'(ops_valid), 32'd0);

    // Digit limit, clear
    press(0, KEY_1, "d1");
    press(1, KEY_2, "d2");
    press(2, KEY_3, "d3");
    press(4, KEY_4, "d4");
    chk("max_digits", 32'(first_num), 32'd123);
    press(11, KEY_C, "kC");
    chk("clear", 32'(first_num), 32'd0);
    press(9, KEY_8, "k8");
    chk("after_clear", 32'(first_num), 32'd8);

    // Two keys in one column: rejected; single held key: one event only
    kv_before = kv_count;
    keys[0] = 1'b1; keys[4] = 1'b1;
    repeat (80) @(negedge clk);
    keys = 16'h0000;
    repeat (80) @(negedge clk);
    chk("multi_nokv", 32'(kv_count), 32'(kv_before));
    keys[0] = 1'b1;
    repeat (80) @(negedge clk);
    keys = 16'h0000;
    repeat (80) @(negedge clk);
    chk("hold_onekv", 32'(kv_count), 32'(kv_before + 1));
    chk("hold_first81", 32'(first_num), 32'd81);

    // Mid-entry star
    press(11, KEY_C, "kC2");
    press(4, KEY_4, "m4");
    press(5, KEY_5, "m5");
    press(3, KEY_A, "mA");
    chk("mid_first", 32'(first_num), 32'd45);
    chk("mid_phase", 32'(entry_phase), 32'(S_SECOND));
    press(12, KEY_STAR, "mStar");
    chk("mstar_first", 32'(first_num), 32'd0);
    chk("mstar_phase", 32'(entry_phase), 32'(S_FIRST));

    // Mid-entry asynchronous reset
    press(4, KEY_4, "r4");
    press(5, KEY_5, "r5");
    press(3, KEY_A, "rA");
    press(0, KEY_1, "r1");
    chk("pre_rst_second", 32'(second_num), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_first", 32'(first_num), 32'd0);
    chk("arst_second", 32'(second_num), 32'd0);
    chk("arst_phase", 32'(entry_phase), 32'(S_FIRST));
    chk("arst_col", 32'(col), 32'h0000000E);
    chk("arst_code", 32'(key_code), 32'(KEY_NONE));
    repeat (3) @(negedge clk);
    kv_before = kv_count;
    rst_ni = 1'b1;
    repeat (64) @(negedge clk);
    chk("post_rst_nokv", 32'(kv_count), 32'(kv_before));
    chk("post_rst_first", 32'(first_num), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
Parametrised successor to the 4x4 keypad front end. It scans an N_ROWS x N_COLS matrix, synchronises and debounces the rows, and rejects multi-key frames. Keypresses become two signed multi-digit operands, with per-operand sign toggle, clear and abort. Finished operand pairs are handed to the downstream arithmetic/display logic through a valid/ready handshake.

Parameters:
N_ROWS, 4, number of row inputs (active-low)
N_COLS, 4, number of column drive outputs (active-low one-hot)
SCAN_DIV, 27000, clk cycles per column slot (1 ms at 27 MHz); elaboration check >= 4
DEBOUNCE_SCANS, 10, consecutive identical full scan frames required for press and for release
MAX_DIGITS, 3, maximum decimal digits per operand
OP_WIDTH, 12, signed operand width; elaboration check 2^(OP_WIDTH-1)-1 >= 10^MAX_DIGITS-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
row  in  N_ROWS  keypad rows, active-low, asynchronous to clk
col  out  N_COLS  column drive, active-low one-hot
key_valid  out  1  one-cycle pulse per debounced press
key_code  out  5  keypad_pkg::key_e of last press
first_num  out  OP_WIDTH  signed first operand (live)
second_num  out  OP_WIDTH  signed second operand (live)
entry_phase  out  2  keypad_pkg::entry_state_e
ops_valid  out  1  operand pair complete
ops_ready  in  1  downstream accepts pair

Behaviour:
- Reset (rst=0, async): col = ~1 (column 0 driven), scan counters 0, debounce state idle, key_valid=0, key_code=KEY_NONE, first_num=second_num=0, entry_phase=S_FIRST, ops_valid=0.
- row passes through a 2-FF synchroniser. The column slot advances every SCAN_DIV cycles, wrapping N_COLS-1 -> 0. Synchronised row is sampled on the last cycle of each slot.
- Frame = one pass over all columns. Frame result: single low bit -> code = r*N_COLS+c; none -> NONE; two or more -> INVALID.
- Debounce: press is accepted after DEBOUNCE_SCANS consecutive frames with the same valid code while released. On acceptance, key_valid pulses one cycle at frame end, with key_code = code_to_key(code). Release is accepted after DEBOUNCE_SCANS consecutive NONE frames. INVALID or a differing code restarts the count. A held key produces no repeat.
- Key map (codes >= 16 -> ignored): row0 1 2 3 A; row1 4 5 6 B; row2 7 8 9 C; row3 * 0 # D.
- Entry FSM; all updates occur the cycle after key_valid:
  - S_FIRST / S_SECOND, digit d: mag = mag*10 + d, only if digit count < MAX_DIGITS; otherwise ignored.
  - B: toggle sign of the current operand. Negating 0 gives 0, but the sign flag is kept for later digits.
  - C: clear the current operand (magnitude, sign, count).
  - A in S_FIRST -> S_SECOND. A in S_SECOND is ignored.
  - # or D in S_SECOND -> S_DONE with ops_valid=1. In S_FIRST they are ignored.
  - * in any state: clear both operands -> S_FIRST, ops_valid=0.
  - S_DONE: operands frozen; digits, A, B, C, # and D are ignored. When ops_valid & ops_ready in the same cycle: transfer, next cycle ops_valid=0, operands=0, S_FIRST. A simultaneous * yields the same result.
- Operand output = sign ? -mag : mag, in two's complement, registered.
- rst asserted mid-scan or mid-entry returns everything to reset values immediately. No event is emitted on deassertion.

Decomposition:
- keypad_pkg: key_e (KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR, KEY_HASH, KEY_NONE), entry_state_e (S_FIRST, S_SECOND, S_DONE), function code_to_key, constant DIGIT_MUL = 10.
- Sub-module keypad_scan_debounce: synchroniser, column scan, frame classification, debounce. Outputs key_valid and key_code.
- Top module: entry FSM and operand registers.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, defaults otherwise; bench model pulls row bit low when its column is driven):
- Reset then idle: col rotates 1110->1101->1011->0111 every 4 cycles; key_valid stays 0, outputs 0.
- Press 1, release, 2, release, A, 3, 4, #: first_num=12, second_num=34, ops_valid=1. Hold ops_ready=0 for 20 cycles, values stable. Pulse ops_ready -> both 0, S_FIRST.
- Enter 5, B, A, 7, B, 9 with release between each, then D: first_num=-5, second_num=-79 (0xFB1 in 12 bits).
- Enter 1,2,3,4: first_num=123 (4th digit ignored). C -> 0. Then 8 -> 8.
- Press 1 and 4 together (same column, two rows) for 5 frames: no key_valid. Hold 1 for 5 frames: exactly one key_valid.
- Mid-entry (first_num=45, S_SECOND) press *: everything 0, S_FIRST. Repeat and assert rst=0 mid-slot: reset values asynchronously.
